// File: rtl/ica_iteration_ctrl_pkg.sv
// rtl/ica_iteration_ctrl_pkg.sv - shared types for the ICA iteration sequencer
// fp_double carries the raw IEEE-754 word type; ica_ctrl_pkg carries the FSM encoding.

package fp_double;

   typedef logic [63:0] double_t;

   localparam double_t DOUBLE_ZERO = 64'h0000_0000_0000_0000;

endpackage

package ica_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      UPD_REQ  = 3'd1,
      UPD_WAIT = 3'd2,
      GAP      = 3'd3,
      CHECK    = 3'd4,
      EVAL     = 3'd5,
      FIN      = 3'd6
   } ctrl_state_t;

   // States that wait on an external engine and are therefore watchdog-bounded.
   function automatic logic is_wait_state(input ctrl_state_t s);
      return (s == UPD_WAIT) || (s == CHECK);
   endfunction

endpackage

// File: rtl/ica_iteration_ctrl_if.sv
// rtl/ica_iteration_ctrl_if.sv - update-engine and convergence-checker handshake bundle
// master = iteration sequencer, slave = update engine plus convergence checker.

interface ica_iteration_ctrl_if #(
   parameter int SIZE_N = 8
);

   logic                              upd_start;
   fp_double::double_t [SIZE_N-1:0]   upd_cur;
   logic                              upd_done;
   fp_double::double_t [SIZE_N-1:0]   upd_vector;

   logic                              conv_start;
   fp_double::double_t [SIZE_N-1:0]   conv_vector;
   fp_double::double_t [SIZE_N-1:0]   conv_next;
   logic                              conv_valid;
   logic                              conv_converged;

   modport master (
      output upd_start,
      output upd_cur,
      input  upd_done,
      input  upd_vector,
      output conv_start,
      output conv_vector,
      output conv_next,
      input  conv_valid,
      input  conv_converged
   );

   modport slave (
      input  upd_start,
      input  upd_cur,
      output upd_done,
      output upd_vector,
      input  conv_start,
      input  conv_vector,
      input  conv_next,
      output conv_valid,
      output conv_converged
   );

endinterface

// File: rtl/ica_iteration_ctrl_vec_reg.sv
// rtl/ica_iteration_ctrl_vec_reg.sv - SIZE_N-element double register with load and clear
// Clear (or reset) wins over load.

module vec_reg
   import fp_double::*;
#(
   parameter int SIZE_N = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  load,
   input  double_t [SIZE_N-1:0]  d,
   output double_t [SIZE_N-1:0]  q
);

   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         q <= {SIZE_N{DOUBLE_ZERO}};
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/ica_iteration_ctrl.sv
// rtl/ica_iteration_ctrl.sv - ICA fixed-point iteration sequencer (update, check, commit loop)
// Optional ICA_ITER_WATCHDOG_EN bounds each UPD_WAIT/CHECK stay to WDOG_CYCLES cycles.

module ica_iteration_ctrl
   import fp_double::*, ica_ctrl_pkg::*;
#(
   parameter int SIZE_N        = 8,
   parameter int MAX_ITER      = 16,
   parameter int CHECK_MIN_LAT = 4,
   parameter int WDOG_CYCLES   = 1024
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  double_t [SIZE_N-1:0]            w_init,
   ica_iteration_ctrl_if.master            bus,
   output double_t [SIZE_N-1:0]            w_out,
   output logic [$clog2(MAX_ITER+1)-1:0]   iter_count,
   output logic                            busy,
   output logic                            done,
   output logic                            converged,
   output logic                            timeout
);

   localparam int ICW = $clog2(MAX_ITER + 1);
   localparam int CW  = $clog2(CHECK_MIN_LAT + 2);

   typedef double_t [SIZE_N-1:0] vec_t;

   ctrl_state_t  state_q;
   ctrl_state_t  state_d;

   vec_t         cur;
   vec_t         nxt;
   vec_t         cur_d;
   logic         cur_load;
   logic         nxt_load;
   logic         wout_load;

   logic [CW-1:0]  chk_cnt_q;
   logic           verdict_q;
   logic           upd_take;
   logic           chk_sample;
   logic [ICW-1:0] iter_next;
   logic           last_round;
   logic           wd_fire;

   assign upd_take   = ((state_q == UPD_REQ) || (state_q == UPD_WAIT)) && bus.upd_done;
   // Verdicts in the first CHECK_MIN_LAT cycles may belong to the previous check.
   assign chk_sample = (state_q == CHECK) && (chk_cnt_q == CW'(CHECK_MIN_LAT)) && bus.conv_valid;
   assign iter_next  = iter_count + 1'b1;
   assign last_round = (iter_next == ICW'(MAX_ITER));

`ifdef ICA_ITER_WATCHDOG_EN
   localparam int WW = $clog2(WDOG_CYCLES + 1);

   logic [WW-1:0] wd_q;

   always_ff @(posedge clk) begin
      if (!rst || (state_d != state_q) || !is_wait_state(state_q)) begin
         wd_q <= '0;
      end else if (wd_q != WW'(WDOG_CYCLES - 1)) begin
         wd_q <= wd_q + 1'b1;
      end
   end

   // A real handshake in the expiry cycle still wins.
   assign wd_fire = is_wait_state(state_q) && (wd_q == WW'(WDOG_CYCLES - 1))
                    && !upd_take && !chk_sample;
`else
   // Watchdog compiled out: constant-false for any legal WDOG_CYCLES.
   assign wd_fire = (WDOG_CYCLES < 0);
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (start) state_d = UPD_REQ;
         UPD_REQ:  state_d = upd_take ? GAP : UPD_WAIT;
         UPD_WAIT: begin
            if (upd_take)     state_d = GAP;
            else if (wd_fire) state_d = FIN;
         end
         GAP:      state_d = CHECK;
         CHECK: begin
            if (chk_sample)   state_d = EVAL;
            else if (wd_fire) state_d = FIN;
         end
         EVAL:     state_d = (verdict_q || last_round) ? FIN : UPD_REQ;
         FIN:      state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.upd_start  = 1'b0;
      bus.conv_start = 1'b0;
      done           = 1'b0;
      busy           = 1'b1;
      cur_load       = 1'b0;
      cur_d          = w_init;
      nxt_load       = upd_take;
      wout_load      = 1'b0;
      case (state_q)
         IDLE: begin
            busy     = 1'b0;
            cur_load = start;
         end
         UPD_REQ:  bus.upd_start  = 1'b1;
         CHECK:    bus.conv_start = 1'b1;
         EVAL: begin
            cur_load = 1'b1;
            cur_d    = nxt;
         end
         FIN: begin
            done      = 1'b1;
            wout_load = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         iter_count <= '0;
         converged  <= 1'b0;
         timeout    <= 1'b0;
         chk_cnt_q  <= '0;
         verdict_q  <= 1'b0;
      end else begin
         if ((state_q == IDLE) && start) begin
            iter_count <= '0;
            converged  <= 1'b0;
            timeout    <= 1'b0;
         end
         if (state_q == EVAL) begin
            iter_count <= iter_next;
            if (verdict_q) begin
               converged <= 1'b1;
            end else if (last_round) begin
               timeout <= 1'b1;
            end
         end
         if (wd_fire) begin
            timeout <= 1'b1;
         end
         if (state_q != CHECK) begin
            chk_cnt_q <= '0;
         end else if (chk_cnt_q != CW'(CHECK_MIN_LAT)) begin
            chk_cnt_q <= chk_cnt_q + 1'b1;
         end
         if (chk_sample) begin
            verdict_q <= bus.conv_converged;
         end
      end
   end

   vec_reg #(.SIZE_N(SIZE_N)) u_cur (
      .clk  (clk),
      .rst  (rst),
      .clr  (1'b0),
      .load (cur_load),
      .d    (cur_d),
      .q    (cur)
   );

   vec_reg #(.SIZE_N(SIZE_N)) u_nxt (
      .clk  (clk),
      .rst  (rst),
      .clr  (1'b0),
      .load (nxt_load),
      .d    (bus.upd_vector),
      .q    (nxt)
   );

   vec_reg #(.SIZE_N(SIZE_N)) u_w_out (
      .clk  (clk),
      .rst  (rst),
      .clr  (1'b0),
      .load (wout_load),
      .d    (cur),
      .q    (w_out)
   );

   assign bus.upd_cur     = cur;
   assign bus.conv_vector = cur;
   assign bus.conv_next   = nxt;

endmodule

// File: tb/tb_ica_iteration_ctrl.sv
// tb/tb_ica_iteration_ctrl.sv - directed bench for ica_iteration_ctrl with engine/checker stubs
// Watchdog sequence runs only when ICA_ITER_WATCHDOG_EN is defined.

module tb_ica_iteration_ctrl;
   import fp_double::*;

   localparam int N = 8;

   typedef double_t [N-1:0] vec_t;

   typedef struct {
      int          upd_lat;
      int          chk_lat;
      logic [15:0] mask;
      int          exp_iter;
      bit          exp_conv;
      bit          exp_to;
      int          exp_cycles;
      int          exp_starts;
      real         exp_w;
   } case_t;

   logic        clk   = 1'b0;
   logic        rst   = 1'b0;
   logic        start = 1'b0;
   vec_t        w_init = '0;
   vec_t        w_out;
   logic [4:0]  iter_count;
   logic        busy;
   logic        done;
   logic        converged;
   logic        timeout;

   ica_iteration_ctrl_if #(.SIZE_N(N)) bus ();

   ica_iteration_ctrl #(
      .SIZE_N        (N),
      .MAX_ITER      (16),
      .CHECK_MIN_LAT (4),
      .WDOG_CYCLES   (20)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .w_init     (w_init),
      .bus        (bus),
      .w_out      (w_out),
      .iter_count (iter_count),
      .busy       (busy),
      .done       (done),
      .converged  (converged),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   int          upd_lat = 1;
   int          chk_lat = 0;
   logic [15:0] conv_mask = '0;
   bit          stale = 1'b0;
   bit          upd_mute = 1'b0;
   int          upd_round = 0;
   int          upd_starts = 0;
   int          upd_wait = -1;
   case_t       cases[5];

   function automatic vec_t fill(input real v);
      return {N{$realtobits(v)}};
   endfunction

   task automatic chk_int(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_vec(input string name, input vec_t act, input vec_t exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Update engine stub: round k returns every element = 0.5*k after upd_lat cycles.
   initial begin
      bus.upd_done   = 1'b0;
      bus.upd_vector = '0;
      forever begin
         @(negedge clk);
         bus.upd_done = 1'b0;
         if (bus.upd_start) begin
            upd_starts++;
            if (!upd_mute) begin
               upd_round++;
               upd_wait = upd_lat;
            end
         end
         if (upd_wait == 0) begin
            bus.upd_done   = 1'b1;
            bus.upd_vector = fill(0.5 * upd_round);
            upd_wait       = -1;
         end else if (upd_wait > 0) begin
            upd_wait--;
         end
      end
   end

   // Checker stub: verdict once conv_start has been high for more than chk_lat cycles.
   initial begin
      int cnt;
      cnt                = 0;
      bus.conv_valid     = 1'b0;
      bus.conv_converged = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.conv_start) cnt++;
         else cnt = 0;
         bus.conv_valid     = stale | (bus.conv_start && (cnt > chk_lat));
         bus.conv_converged = stale | (((upd_round >= 1) && (upd_round <= 16)) ?
                                       conv_mask[upd_round-1] : 1'b0);
      end
   end

   task automatic run_case(input int l, input int c, input logic [15:0] m, input bit st,
                           input bit inject, output int n, output int cc);
      int inj;
      upd_lat    = l;
      chk_lat    = c;
      conv_mask  = m;
      stale      = st;
      upd_round  = 0;
      upd_starts = 0;
      upd_wait   = -1;
      w_init     = fill(1.0);
      inj        = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n  = 1;
      cc = 0;
      while (!done && (n < 400)) begin
         if (bus.conv_start) cc++;
         if (inject) begin
            if (inj == 1) begin
               start = 1'b0;
               chk_vec("busy_start_conv_vector", bus.conv_vector, fill(1.0));
               chk_vec("busy_start_upd_cur", bus.upd_cur, fill(1.0));
               inj = 2;
            end else if ((inj == 0) && bus.conv_start) begin
               start  = 1'b1;
               w_init = fill(9.0);
               inj    = 1;
            end
         end
         @(negedge clk);
         n++;
      end
      if (!done) begin
         n_vec++;
         n_err++;
         $display("FAIL run_timeout: done not seen within %0d cycles", n);
      end
   endtask

   initial begin
      int n;
      int cc;
      bit saw;

      cases[0] = '{1, 0, 16'h0004,  3, 1'b1, 1'b0,  28,  3, 1.5};
      cases[1] = '{1, 0, 16'h0000, 16, 1'b0, 1'b1, 145, 16, 8.0};
      cases[2] = '{0, 0, 16'h0001,  1, 1'b1, 1'b0,   9,  1, 0.5};
      cases[3] = '{3, 6, 16'h0002,  2, 1'b1, 1'b0,  27,  2, 1.0};
      cases[4] = '{2, 4, 16'h0080,  8, 1'b1, 1'b0,  81,  8, 4.0};

      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk_int("rst_busy", int'(busy), 0);
      chk_int("rst_done", int'(done), 0);
      chk_int("rst_iter", int'(iter_count), 0);
      chk_int("rst_flags", int'({converged, timeout}), 0);
      chk_int("rst_starts", int'({bus.upd_start, bus.conv_start}), 0);
      chk_vec("rst_w_out", w_out, '0);
      chk_vec("rst_conv_next", bus.conv_next, '0);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         run_case(cases[i].upd_lat, cases[i].chk_lat, cases[i].mask, 1'b0, 1'b0, n, cc);
         chk_int($sformatf("v%0d_cycles", i), n, cases[i].exp_cycles);
         chk_int($sformatf("v%0d_iter", i), int'(iter_count), cases[i].exp_iter);
         chk_int($sformatf("v%0d_converged", i), int'(converged), int'(cases[i].exp_conv));
         chk_int($sformatf("v%0d_timeout", i), int'(timeout), int'(cases[i].exp_to));
         chk_int($sformatf("v%0d_upd_starts", i), upd_starts, cases[i].exp_starts);
         @(negedge clk);
         chk_vec($sformatf("v%0d_w_out", i), w_out, fill(cases[i].exp_w));
         chk_int($sformatf("v%0d_done_pulse", i), int'(done), 0);
         chk_int($sformatf("v%0d_busy_after", i), int'(busy), 0);
      end

      // Stale verdict held high from the start: EVAL only after CHECK_MIN_LAT masked cycles.
      run_case(1, 0, 16'h0001, 1'b1, 1'b0, n, cc);
      chk_int("stale_check_cycles", cc, 5);
      chk_int("stale_cycles", n, 10);
      chk_int("stale_iter", int'(iter_count), 1);
      chk_int("stale_converged", int'(converged), 1);
      @(negedge clk);
      stale = 1'b0;

      run_case(1, 0, 16'h0004, 1'b0, 1'b1, n, cc);
      chk_int("busy_start_cycles", n, 28);
      chk_int("busy_start_iter", int'(iter_count), 3);
      chk_int("busy_start_converged", int'(converged), 1);
      @(negedge clk);
      chk_vec("busy_start_w_out", w_out, fill(1.5));

      // Reset while waiting on the update engine in round 2.
      upd_lat    = 3;
      chk_lat    = 0;
      conv_mask  = '0;
      upd_round  = 0;
      upd_starts = 0;
      upd_wait   = -1;
      w_init     = fill(1.0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!(bus.upd_start && (iter_count == 5'd1)) && (n < 100)) begin
         @(negedge clk);
         n++;
      end
      chk_int("mid_reach_round2", int'(bus.upd_start), 1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_int("mid_busy", int'(busy), 0);
      chk_int("mid_done", int'(done), 0);
      chk_int("mid_iter", int'(iter_count), 0);
      chk_int("mid_flags", int'({converged, timeout}), 0);
      chk_int("mid_starts", int'({bus.upd_start, bus.conv_start}), 0);
      chk_vec("mid_w_out", w_out, '0);
      chk_vec("mid_upd_cur", bus.upd_cur, '0);
      chk_vec("mid_conv_next", bus.conv_next, '0);
      rst = 1'b1;
      saw = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (done || busy) saw = 1'b1;
      end
      chk_int("mid_no_done", int'(saw), 0);
      run_case(1, 0, 16'h0001, 1'b0, 1'b0, n, cc);
      chk_int("mid_rerun_cycles", n, 10);
      chk_int("mid_rerun_iter", int'(iter_count), 1);
      chk_int("mid_rerun_converged", int'(converged), 1);
      @(negedge clk);

`ifdef ICA_ITER_WATCHDOG_EN
      upd_mute = 1'b1;
      run_case(1, 0, 16'h0000, 1'b0, 1'b0, n, cc);
      chk_int("wdog_cycles", n, 22);
      chk_int("wdog_timeout", int'(timeout), 1);
      chk_int("wdog_converged", int'(converged), 0);
      chk_int("wdog_iter", int'(iter_count), 0);
      chk_int("wdog_upd_starts", upd_starts, 1);
      @(negedge clk);
      chk_vec("wdog_w_out", w_out, fill(1.0));
      upd_mute = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ica_iteration_ctrl.md
Name: ica_iteration_ctrl

Overview:
- Fixed-point iteration sequencer for the ICA weight-vector loop, directly upstream of the convergence checker.
- Holds the current weight vector and requests the next vector from the update engine.
- Presents current and next vectors to the checker and holds its start level until a verdict returns.
- Loops until the checker reports convergence or the iteration budget is exhausted, then exports the final vector.

Parameters:
- SIZE_N, 8, vector length (rows; single column).
- MAX_ITER, 16, maximum update/check rounds before giving up.
- CHECK_MIN_LAT, 4, CHECK cycles during which conv_valid is ignored (masks stale verdicts).
- WDOG_CYCLES, 1024, watchdog limit per wait state (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- start  in  1  pulse; begins a run using w_init.
- w_init  in  double[SIZE_N][1]  initial weight vector.
- upd_start  out  1  one-cycle request to the update engine.
- upd_cur  out  double[SIZE_N][1]  current vector given to the update engine (registered).
- upd_done  in  1  pulse; upd_vector valid this cycle.
- upd_vector  in  double[SIZE_N][1]  next vector from the update engine.
- conv_start  out  1  level start to the convergence checker.
- conv_vector  out  double[SIZE_N][1]  current vector (registered, stable during CHECK).
- conv_next  out  double[SIZE_N][1]  next vector (registered, stable during CHECK).
- conv_valid  in  1  checker verdict valid.
- conv_converged  in  1  checker verdict.
- w_out  out  double[SIZE_N][1]  committed vector.
- iter_count  out  $clog2(MAX_ITER+1)  completed rounds.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- converged  out  1  sticky result flag.
- timeout  out  1  sticky result flag.

Behaviour:
- Reset (rst==0 at clk edge): state IDLE. All outputs 0. Vector registers cleared to 0.0. Any run in progress is aborted with no done pulse.
- IDLE: on start, latch w_init into cur. Clear iter_count, converged and timeout. busy<=1. Go to UPD_REQ.
- start is ignored while busy=1.
- UPD_REQ: upd_start=1 for exactly one cycle. Go to UPD_WAIT.
- UPD_WAIT: on upd_done, latch upd_vector into nxt. Go to GAP.
  - A upd_done arriving in UPD_REQ is accepted the same way.
- GAP: one cycle with conv_start=0, so every check begins from a low start level. Go to CHECK.
- CHECK: conv_start=1, held. Internal counter counts cycles in CHECK.
  - conv_valid is sampled only once the counter >= CHECK_MIN_LAT. Go to EVAL on the first sampled conv_valid=1.
- EVAL (conv_start=0): cur<=nxt, iter_count+1. Then:
  - conv_converged=1 → converged<=1, go to FIN.
  - Otherwise, if new iter_count == MAX_ITER → timeout<=1, go to FIN.
  - Otherwise → go to UPD_REQ.
- FIN: w_out<=cur (the committed last next vector). done=1 for one cycle, busy<=0. Go to IDLE.
- Result flags: converged and timeout persist until the next accepted start. They are never both 1.
- Pass-through: upd_cur and conv_vector always equal cur; conv_next always equals nxt.
- Latency: minimum start-to-done = 2 + update latency + 1 + CHECK_MIN_LAT + 2 cycles.
- Inputs ignored by state:
  - upd_done outside UPD_REQ/UPD_WAIT is ignored.
  - conv_valid outside CHECK is ignored.
- MAX_ITER==1: a single round, ending with either converged or timeout.

Optional Feature:
- Macro ICA_ITER_WATCHDOG_EN.
- Defined: a counter runs in UPD_WAIT and in CHECK, reset on each entry to either state. Reaching WDOG_CYCLES forces FIN with timeout=1, converged=0, and w_out=cur (nxt not committed).
- Undefined: waits are unbounded and WDOG_CYCLES is unused.

Decomposition:
- Package fp_double: double typedef and constant DOUBLE_ZERO for vector clearing.
- Package ica_ctrl_pkg: state enum (IDLE, UPD_REQ, UPD_WAIT, GAP, CHECK, EVAL, FIN).
- One sub-module: vec_reg (SIZE_N double register with load enable and clear), instantiated for cur, nxt and w_out.

Test Plan:
- Converge on round 3: w_init all 1.0. Update stub returns 0.5·k per round. Checker stub gives converged=0, 0, 1 → done at round 3, iter_count=3, converged=1, timeout=0, w_out = third upd_vector.
- Budget exhausted: MAX_ITER=16, checker always converged=0 → done with iter_count=16, timeout=1, converged=0; exactly 16 upd_start pulses seen.
- Stale verdict: conv_valid held 1 across GAP and first CHECK cycles with converged=1 → not sampled before CHECK_MIN_LAT cycles; EVAL occurs at CHECK cycle 4, not before.
- Reset mid-run: drive rst=0 in UPD_WAIT at round 2 → next cycle busy=0, no done, all outputs and vectors 0. A later start runs cleanly from iter_count=0.
- Start while busy: pulse start with different w_init during CHECK → ignored; cur unchanged, run completes normally.
- Watchdog, ICA_ITER_WATCHDOG_EN defined, WDOG_CYCLES=20: upd_done never arrives → done 20 cycles after entering UPD_WAIT, timeout=1, w_out = w_init.
